// File: rtl/led_bank_pkg.sv
// Shared types for the LED blinker bank: channel modes and the per-channel
// configuration bundle carried from the config port to each channel.
package led_bank_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    // Fields are sized for the widest supported counter; channels use the low CNT_W bits.
    localparam int CFG_W = 32;

    typedef struct packed {
        mode_t              mode;
        logic [CFG_W-1:0]   period;
        logic [CFG_W-1:0]   duty;
    } chan_cfg_t;

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/period/duty registers, phase counter, blink toggle
// and the registered LED output derived from next-state values.
module led_channel
    import led_bank_pkg::*;
#(
    parameter int    CNT_W      = 16,
    parameter mode_t DEF_MODE   = MODE_BLINK,
    parameter int    DEF_PERIOD = 500
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    input  logic      tick,
    input  logic      wr,
    input  chan_cfg_t cfg_i,
    output logic      led_o
);

    mode_t              mode_q,   mode_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   duty_q,   duty_d;
    logic [CNT_W-1:0]   phase_q,  phase_d;
    logic               tgl_q,    tgl_d;
    logic               led_q,    led_d;
    logic [CNT_W-1:0]   peff;

    // Upper config bits beyond CNT_W are intentionally dropped.
    if (CNT_W < CFG_W) begin : g_cfg_hi
        logic cfg_unused;
        assign cfg_unused = ^{cfg_i.period[CFG_W-1:CNT_W], cfg_i.duty[CFG_W-1:CNT_W]};
    end

    always_comb begin
        peff     = (period_q == '0) ? CNT_W'(1) : period_q;
        mode_d   = mode_q;
        period_d = period_q;
        duty_d   = duty_q;
        phase_d  = phase_q;
        tgl_d    = tgl_q;
        led_d    = 1'b0;

        // A write beats a coincident tick: the channel restarts from phase 0.
        if (wr) begin
            mode_d   = cfg_i.mode;
            period_d = cfg_i.period[CNT_W-1:0];
            duty_d   = cfg_i.duty[CNT_W-1:0];
            phase_d  = '0;
            tgl_d    = 1'b0;
        end else if (tick) begin
            if (phase_q >= peff - 1'b1) begin
                phase_d = '0;
                if (mode_q == MODE_BLINK) begin
                    tgl_d = ~tgl_q;
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end

        case (mode_d)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = tgl_d;
            MODE_PWM:   led_d = (phase_d < duty_d);
            default:    led_d = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q   <= DEF_MODE;
            period_q <= CNT_W'(DEF_PERIOD);
            duty_q   <= CNT_W'(DEF_PERIOD / 2);
            phase_q  <= '0;
            tgl_q    <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            phase_q  <= phase_d;
            tgl_q    <= tgl_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_blinker_bank.sv
// Bank of NCH run-time configurable LED drivers sharing one prescaler tick,
// with a single-cycle config write port acknowledged one cycle later.
module led_blinker_bank
    import led_bank_pkg::*;
#(
    parameter int    NCH        = 8,
    parameter int    TICK_DIV   = 100000,
    parameter int    CNT_W      = 16,
    parameter mode_t DEF_MODE   = MODE_BLINK,
    parameter int    DEF_PERIOD = 500,
    localparam int   CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             tick,
    output logic [NCH-1:0]   led
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_w;
    logic             ch_valid;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [NCH-1:0]   wr_vec;
    chan_cfg_t        cfg_bus;

    always_comb begin
        tick_w    = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = tick_w ? '0 : pre_cnt_q + 1'b1;

        ch_valid  = (32'(cfg_ch) < 32'(NCH));
        ack_d     = cfg_we;
        err_d     = cfg_we & ~ch_valid;

        cfg_bus.mode   = mode_t'(cfg_mode);
        cfg_bus.period = CFG_W'(cfg_period);
        cfg_bus.duty   = CFG_W'(cfg_duty);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_cnt_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign wr_vec[gi] = cfg_we & ch_valid & (cfg_ch == CH_W'(gi));

        led_channel #(
            .CNT_W      (CNT_W),
            .DEF_MODE   (DEF_MODE),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .tick    (tick_w),
            .wr      (wr_vec[gi]),
            .cfg_i   (cfg_bus),
            .led_o   (led[gi])
        );
    end

    assign tick    = tick_w;
    assign cfg_ack = ack_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_led_blinker_bank.sv
// Scoreboard bench for led_blinker_bank: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_led_blinker_bank;
    import led_bank_pkg::*;

    localparam int NCH = 6;
    localparam int CH_W = 3;
    localparam int CNT_W = 16;

    typedef struct {
        int         cyc;
        logic [5:0] mask;
        logic [5:0] val;
        string      name;
    } led_exp_t;

    typedef struct {
        int   cyc;
        logic err;
    } ack_exp_t;

    logic             clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [1:0]       cfg_mode = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic [CNT_W-1:0] cfg_duty = '0;
    logic             cfg_ack;
    logic             cfg_err;
    logic             tick;
    logic [NCH-1:0]   led;

    int abs_cyc = 0;
    int cyc = 0;
    int base = 0;
    bit started = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    led_exp_t led_q[$];
    ack_exp_t ack_q[$];

    led_blinker_bank #(
        .NCH        (NCH),
        .TICK_DIV   (4),
        .CNT_W      (CNT_W),
        .DEF_MODE   (MODE_BLINK),
        .DEF_PERIOD (3)
    ) dut (
        .sys_clk    (clk),
        .sys_rst    (sys_rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_ack    (cfg_ack),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .led        (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        abs_cyc <= abs_cyc + 1;
        if (sys_rst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s @abs %0d: got %0h, expected %0h", nm, abs_cyc, act, exp);
        end
    endtask

    task automatic exp_led(int rel, logic [5:0] m, logic [5:0] v, string nm);
        led_q.push_back('{base + rel, m, v, nm});
    endtask

    task automatic wait_rel(int rel);
        if (abs_cyc > base + rel) check("schedule", abs_cyc, base + rel);
        while (abs_cyc < base + rel) @(negedge clk);
    endtask

    task automatic write_at(int rel, int ch, mode_t m, int per, int dty);
        wait_rel(rel);
        cfg_we = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_mode = m;
        cfg_period = CNT_W'(per);
        cfg_duty = CNT_W'(dty);
        ack_q.push_back('{base + rel + 1, (ch >= NCH)});
        $display("[TB] write rel %0d ch=%0d mode=%0d period=%0d duty=%0d", rel, ch, m, per, dty);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        cfg_we = 1'b0;
        @(negedge clk);
        started = 1'b1;
        base = abs_cyc + 1;
        exp_led(0, 6'h3F, 6'h00, "reset_led");
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    // Monitor: tick schedule every cycle, ack/err against queue, led expectations by cycle.
    always @(negedge clk) begin
        logic exp_ack, exp_err;
        led_exp_t e;
        if (started) begin
            check("tick", {31'd0, tick}, {31'd0, (cyc % 4) == 3});
            exp_ack = 1'b0;
            exp_err = 1'b0;
            while (ack_q.size() > 0 && ack_q[0].cyc < abs_cyc) begin
                check("ack_missing", 32'd0, 32'd1);
                void'(ack_q.pop_front());
            end
            if (ack_q.size() > 0 && ack_q[0].cyc == abs_cyc) begin
                exp_ack = 1'b1;
                exp_err = ack_q[0].err;
                void'(ack_q.pop_front());
            end
            check("cfg_ack", {31'd0, cfg_ack}, {31'd0, exp_ack});
            check("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
            while (led_q.size() > 0 && led_q[0].cyc <= abs_cyc) begin
                e = led_q.pop_front();
                if (e.cyc < abs_cyc) check({"missed_", e.name}, 32'd0, 32'd1);
                else check(e.name, {26'd0, led & e.mask}, {26'd0, e.val});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset defaults: blink period 3 -> rise end of 11, fall end of 23.
        do_reset();
        exp_led(11, 6'h3F, 6'h00, "dflt_c11");
        exp_led(12, 6'h3F, 6'h3F, "dflt_c12");
        exp_led(23, 6'h3F, 6'h3F, "dflt_c23");
        exp_led(24, 6'h3F, 6'h00, "dflt_c24");
        exp_led(35, 6'h3F, 6'h00, "dflt_c35");
        exp_led(36, 6'h3F, 6'h3F, "dflt_c36");
        wait_rel(40);

        // PWM on channel 2, then the duty/period corner cases.
        do_reset();
        exp_led(1,   6'h04, 6'h04, "pwm_c1");
        exp_led(11,  6'h04, 6'h04, "pwm_c11");
        exp_led(12,  6'h04, 6'h00, "pwm_c12");
        exp_led(39,  6'h04, 6'h00, "pwm_c39");
        exp_led(40,  6'h04, 6'h04, "pwm_c40");
        exp_led(51,  6'h04, 6'h04, "pwm_c51");
        exp_led(52,  6'h04, 6'h00, "pwm_c52");
        exp_led(61,  6'h04, 6'h00, "duty0_c61");
        exp_led(80,  6'h04, 6'h00, "duty0_c80");
        exp_led(100, 6'h04, 6'h00, "duty0_c100");
        exp_led(101, 6'h04, 6'h04, "duty12_c101");
        exp_led(140, 6'h04, 6'h04, "duty12_c140");
        exp_led(150, 6'h04, 6'h04, "duty12_c150");
        exp_led(151, 6'h04, 6'h04, "per0_c151");
        exp_led(175, 6'h04, 6'h04, "per0_c175");
        write_at(0,   2, MODE_PWM, 10, 3);
        write_at(60,  2, MODE_PWM, 10, 0);
        write_at(100, 2, MODE_PWM, 10, 12);
        write_at(150, 2, MODE_PWM, 0, 1);
        wait_rel(180);

        // Mid-blink rewrite of channel 1 while tgl=1; other channels untouched.
        do_reset();
        exp_led(16, 6'h02, 6'h02, "mid_c16");
        exp_led(17, 6'h02, 6'h00, "mid_c17");
        exp_led(17, 6'h3D, 6'h3D, "mid_others_c17");
        exp_led(23, 6'h3D, 6'h3D, "mid_others_c23");
        exp_led(24, 6'h3D, 6'h00, "mid_others_c24");
        exp_led(27, 6'h02, 6'h00, "mid_c27");
        exp_led(28, 6'h02, 6'h02, "mid_c28");
        exp_led(36, 6'h3D, 6'h3D, "mid_others_c36");
        exp_led(39, 6'h02, 6'h02, "mid_c39");
        exp_led(40, 6'h02, 6'h00, "mid_c40");
        write_at(16, 1, MODE_BLINK, 3, 0);
        wait_rel(44);

        // Write on a tick cycle (19) to channel 3: phase must restart at 0.
        do_reset();
        exp_led(20, 6'h08, 6'h08, "wt_c20");
        exp_led(23, 6'h08, 6'h08, "wt_c23");
        exp_led(24, 6'h08, 6'h00, "wt_c24");
        exp_led(35, 6'h08, 6'h00, "wt_c35");
        exp_led(36, 6'h08, 6'h08, "wt_c36");
        write_at(19, 3, MODE_PWM, 4, 1);
        wait_rel(40);

        // Out-of-range channels back-to-back with a valid write.
        do_reset();
        exp_led(6,  6'h3F, 6'h00, "oor_c6");
        exp_led(7,  6'h3F, 6'h00, "oor_c7");
        exp_led(8,  6'h3F, 6'h01, "oor_c8");
        exp_led(12, 6'h3F, 6'h3F, "oor_c12");
        exp_led(24, 6'h3F, 6'h01, "oor_c24");
        write_at(5, 6, MODE_OFF, 1, 0);
        write_at(6, 7, MODE_ON, 1, 0);
        write_at(7, 0, MODE_ON, 5, 0);
        wait_rel(28);

        // Reset asserted together with a write: write is dropped, schedule restarts.
        do_reset();
        exp_led(3,  6'h3F, 6'h01, "rst_pre_c3");
        exp_led(10, 6'h3F, 6'h01, "rst_pre_c10");
        write_at(2, 0, MODE_ON, 3, 0);
        wait_rel(10);
        sys_rst = 1'b1;
        cfg_we = 1'b1;
        cfg_ch = '0;
        cfg_mode = MODE_ON;
        cfg_period = CNT_W'(3);
        cfg_duty = '0;
        $display("[TB] write with reset ch=0 mode=%0d (expected dropped)", MODE_ON);
        base = base + 11;
        exp_led(0,  6'h3F, 6'h00, "rst_c0");
        exp_led(1,  6'h3F, 6'h00, "rst_c1");
        exp_led(11, 6'h3F, 6'h00, "rst_c11");
        exp_led(12, 6'h3F, 6'h3F, "rst_c12");
        @(negedge clk);
        sys_rst = 1'b0;
        cfg_we = 1'b0;
        wait_rel(16);

        check("led_queue_empty", led_q.size(), 0);
        check("ack_queue_empty", ack_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_blinker_bank.md
# led_blinker_bank

Parametrised bank of NCH independent LED drivers for the FPGA board LEDs. It generalises the fixed free-running heartbeat blinkers into run-time configurable channels, each OFF, ON, BLINK or PWM-dimmed. All timing derives from one shared prescaler tick. It sits in the sys_clk domain beside the video path, and its config port is driven by a register bank or by tie-offs.

## Interface
Parameters:
- NCH, 8: number of LED channels (1..32).
- TICK_DIV, 100000: sys_clk cycles per tick. Override with a small value under SIMULATION.
- CNT_W, 16: width of the period, duty and phase counters.
- DEF_MODE, MODE_BLINK: mode of every channel after reset.
- DEF_PERIOD, 500: period of every channel after reset, in ticks.

Ports:
- sys_clk  in  1: system clock. One clock only; reset is synchronous and active-high.
- sys_rst  in  1: synchronous, active-high reset.
- cfg_we  in  1: config write strobe, single cycle.
- cfg_ch  in  $clog2(NCH) (min 1): target channel.
- cfg_mode  in  2: mode_t value.
- cfg_period  in  CNT_W: period in ticks.
- cfg_duty  in  CNT_W: PWM high time in ticks.
- cfg_ack  out  1: registered pulse, one cycle after every cfg_we.
- cfg_err  out  1: registered pulse with cfg_ack when cfg_ch >= NCH.
- tick  out  1: one-cycle prescaler strobe, exported for debug and other timers.
- led  out  NCH: registered LED drive, 1 = lit.

## Operation
- Prescaler:
  - pre_cnt counts 0..TICK_DIV-1, then wraps to 0.
  - tick = 1 exactly while pre_cnt == TICK_DIV-1.
- Per channel state: mode, period, duty, phase (CNT_W bits), tgl (1 bit).
- Effective period peff = max(period, 1). Period 0 behaves as 1.
- On each tick, phase advances: phase = (phase == peff-1) ? 0 : phase+1.
- In BLINK, tgl inverts when phase wraps to 0. Otherwise tgl holds.
- LED function, computed from next-state values:
  - OFF: 0.
  - ON: 1.
  - BLINK: tgl. One full cycle lasts 2*peff ticks at 50% duty.
  - PWM: (phase < duty). duty 0 gives always 0; duty >= peff gives always 1.
- Config write when cfg_we = 1 and cfg_ch < NCH:
  - Load mode, period and duty into the channel.
  - Clear phase and tgl.
  - Other channels are unaffected.
- cfg_ch >= NCH: no state changes; cfg_ack and cfg_err both pulse.
- Write and tick on the same channel in the same cycle: the write wins, so phase = 0 and tgl = 0.
- cfg_mode is 2 bits, so every value is a legal mode_t.

## Timing
- Reset values:
  - pre_cnt 0.
  - Every phase 0 and every tgl 0.
  - mode = DEF_MODE, period = DEF_PERIOD, duty = DEF_PERIOD/2 (integer division).
  - led = all 0, tick 0, cfg_ack 0, cfg_err 0.
- sys_rst asserted at any point, including mid-write or on a tick, overrides everything on that edge.
- First tick: cycle TICK_DIV-1, counting the first cycle with sys_rst low as cycle 0. Ticks then repeat every TICK_DIV cycles.
- phase, tgl and led all update on the edge that ends the tick cycle. The led output therefore adds no extra latency.
- A write takes effect on the edge that ends the cfg_we cycle:
  - led shows the new mode's value from the next cycle.
  - cfg_ack and cfg_err are high in that same next cycle.
- Back-to-back cfg_we on consecutive cycles are legal. Each is acknowledged, with no stall.

## Structure
- Package led_bank_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_OFF = 0, MODE_ON = 1, MODE_BLINK = 2, MODE_PWM = 3}.
  - A struct chan_cfg_t {mode, period, duty}.
- Sub-module led_channel holds one channel's registers and LED function. It takes sys_clk, sys_rst, tick, wr, a cfg struct, and drives led_o. It is instantiated NCH times with a generate loop.
- The top holds the prescaler, channel decode and ack/err registers.

## Test plan
- Reset defaults, with TICK_DIV=4, DEF_PERIOD=3, DEF_MODE=BLINK:
  - After reset release, ticks occur at cycles 3, 7, 11, …
  - Every led bit rises at the end of cycle 11 and falls at the end of cycle 23.
- PWM, period=10, duty=3 on channel 2:
  - led[2] is high for 3 of every 10 ticks.
  - duty=0 gives constant 0; duty=12 gives constant 1; period=0 with duty=1 gives constant 1.
- Write mid-blink on channel 1 while tgl=1:
  - led[1] is 0 on the next cycle and cfg_ack pulses once.
  - The next toggle lands exactly peff ticks later.
  - All other channels remain cycle-identical to a reference run.
- Simultaneous write and tick on the same channel: phase = 0 afterwards, and no extra advance is seen.
- cfg_ch = NCH (out of range) on an NCH=6 build:
  - cfg_ack = cfg_err = 1 for one cycle.
  - No channel changes.
- Reset pulse mid-operation, including during cfg_we:
  - All outputs return to their reset values on the next edge.
  - The tick schedule restarts from cycle 0.
